mem_stage: RTL and testbench

- Pipeline stage directly downstream of the execute stage.
- Consumes the ALU result, store data and destination index, and performs single-outstanding data-memory loads and stores over a request/grant/response interface.
- Presents one registered writeback beat per retired instruction to the register-file writeback port.
- Stalls the execute stage while a memory access is in flight.

---
 rtl/mem_stage.sv | 212 +++++++++++++++++++++
 tb/tb_mem_stage.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: memory pipeline stage after execute.
// ALU results retire the cycle after they are accepted. Loads and stores are
// issued one at a time over a request/grant/response port. The execute stage
// is stalled while an access is outstanding.
module mem_stage #(
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_output_valid,
    input  logic        ldst_valid_idix_p1,
    input  logic        st_idix_p1,
    input  logic [15:0] rd_p1,
    input  logic [15:0] rt_p1,
    input  logic [2:0]  rd_idx_p1,
    input  logic        wr_idix_p1,
    input  logic        flush_p1,
    output logic        mem_stall_p1,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [15:0] dmem_addr,
    output logic [15:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [15:0] dmem_rdata,
    output logic        wb_valid,
    output logic        wb_wr,
    output logic [2:0]  wb_rd,
    output logic [15:0] wb_data,
    output logic        wb_excep
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    // The WAIT cycle in which the counter steps up to TIMEOUT_CYC-1 is the last
    // one, so an unanswered load raises its exception TIMEOUT_CYC cycles after
    // the grant. TIMEOUT_CYC must be at least 2.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 2);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t state_reg, state_next;

    logic [15:0]      addr_reg;
    logic [15:0]      wdata_reg;
    logic [2:0]       idx_reg;
    logic             wr_reg;
    logic             st_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             discard_reg;

    logic             wb_valid_reg;
    logic             wb_wr_reg;
    logic [2:0]       wb_rd_reg;
    logic [15:0]      wb_data_reg;
    logic             wb_excep_reg;

    logic accept;
    logic accept_mem;
    logic timeout_hit;
    logic discard_any;

    assign accept      = alu_output_valid && (state_reg == S_IDLE) && !flush_p1;
    assign accept_mem  = accept && ldst_valid_idix_p1;
    assign timeout_hit = (state_reg == S_WAIT) && (cnt_reg == CNT_LAST);
    // A flush arriving in the completion cycle itself also discards the result.
    assign discard_any = discard_reg || flush_p1;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: a grant always wins over a flush in REQ because the
    // access has already been handed to memory.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (accept_mem) begin
                    state_next = S_REQ;
                end
            end
            S_REQ: begin
                if (dmem_gnt) begin
                    state_next = st_reg ? S_IDLE : S_WAIT;
                end else if (flush_p1) begin
                    state_next = S_IDLE;
                end
            end
            S_WAIT: begin
                if (dmem_rvalid || timeout_hit) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Memory-side and stall outputs decoded from the current state.
    always_comb begin
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        mem_stall_p1 = accept_mem;
        if (state_reg == S_REQ) begin
            dmem_req = 1'b1;
            dmem_we  = st_reg;
        end
        if (state_reg != S_IDLE) begin
            mem_stall_p1 = 1'b1;
        end
    end

    assign dmem_addr  = addr_reg;
    assign dmem_wdata = wdata_reg;

    // Capture the instruction on accept; the values stay put while it is in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            addr_reg  <= 16'h0000;
            wdata_reg <= 16'h0000;
            idx_reg   <= 3'd0;
            wr_reg    <= 1'b0;
            st_reg    <= 1'b0;
        end else if (accept) begin
            addr_reg  <= rd_p1;
            wdata_reg <= rt_p1;
            idx_reg   <= rd_idx_p1;
            wr_reg    <= wr_idix_p1;
            st_reg    <= ldst_valid_idix_p1 && st_idix_p1;
        end
    end

    // Timeout counter and sticky discard flag for a flushed in-flight access.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_reg     <= '0;
            discard_reg <= 1'b0;
        end else begin
            if (state_reg == S_REQ && dmem_gnt) begin
                cnt_reg <= '0;
            end else if (state_reg == S_WAIT) begin
                cnt_reg <= cnt_reg + CNT_ONE;
            end
            if (state_next == S_IDLE) begin
                discard_reg <= 1'b0;
            end else if (flush_p1 && state_reg != S_IDLE) begin
                discard_reg <= 1'b1;
            end
        end
    end

    // Registered writeback beat; valid and exception are one-cycle pulses.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wb_valid_reg <= 1'b0;
            wb_wr_reg    <= 1'b0;
            wb_rd_reg    <= 3'd0;
            wb_data_reg  <= 16'h0000;
            wb_excep_reg <= 1'b0;
        end else begin
            wb_valid_reg <= 1'b0;
            wb_excep_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (accept && !ldst_valid_idix_p1) begin
                        wb_valid_reg <= 1'b1;
                        wb_wr_reg    <= wr_idix_p1;
                        wb_rd_reg    <= rd_idx_p1;
                        wb_data_reg  <= rd_p1;
                    end
                end
                S_REQ: begin
                    if (dmem_gnt && st_reg && !flush_p1) begin
                        wb_valid_reg <= 1'b1;
                        wb_wr_reg    <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (dmem_rvalid) begin
                        if (!discard_any) begin
                            wb_valid_reg <= 1'b1;
                            wb_wr_reg    <= wr_reg;
                            wb_rd_reg    <= idx_reg;
                            wb_data_reg  <= dmem_rdata;
                        end
                    end else if (timeout_hit && !discard_any) begin
                        wb_valid_reg <= 1'b1;
                        wb_wr_reg    <= 1'b0;
                        wb_excep_reg <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign wb_valid = wb_valid_reg;
    assign wb_wr    = wb_wr_reg;
    assign wb_rd    = wb_rd_reg;
    assign wb_data  = wb_data_reg;
    assign wb_excep = wb_excep_reg;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized bench for mem_stage. Each accepted instruction is
// turned into a timeline (request window, grant, response, retire cycle) by
// plain arithmetic. Every cycle the DUT outputs are compared to that timeline.
// Directed scenarios at the start pin the timeline with literal values.
module tb_mem_stage;
    localparam int T    = 4;
    localparam int MAXC = 16384;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_output_valid, ldst_valid_idix_p1, st_idix_p1;
    logic [15:0] rd_p1, rt_p1;
    logic [2:0]  rd_idx_p1;
    logic        wr_idix_p1, flush_p1;
    logic        mem_stall_p1, dmem_req, dmem_we;
    logic [15:0] dmem_addr, dmem_wdata;
    logic        dmem_gnt, dmem_rvalid;
    logic [15:0] dmem_rdata;
    logic        wb_valid, wb_wr, wb_excep;
    logic [2:0]  wb_rd;
    logic [15:0] wb_data;

    mem_stage #(.TIMEOUT_CYC(T), .CNT_W(3)) dut (
        .clk(clk), .rst(rst),
        .alu_output_valid(alu_output_valid), .ldst_valid_idix_p1(ldst_valid_idix_p1),
        .st_idix_p1(st_idix_p1), .rd_p1(rd_p1), .rt_p1(rt_p1), .rd_idx_p1(rd_idx_p1),
        .wr_idix_p1(wr_idix_p1), .flush_p1(flush_p1), .mem_stall_p1(mem_stall_p1),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_wr(wb_wr), .wb_rd(wb_rd), .wb_data(wb_data), .wb_excep(wb_excep)
    );

    always #5 clk = ~clk;

    // kind: 0 = ALU, 1 = load, 2 = store. d = grant delay, r = response delay
    // after the cycle following grant, foff = flush offset (-1 none, 99 random).
    typedef struct {
        int          kind;
        logic [15:0] a;
        logic [15:0] w;
        logic [2:0]  idx;
        logic        wr;
        int          d;
        int          r;
        int          foff;
        logic        use_rd;
        logic [15:0] rdat;
    } op_t;

    typedef struct {
        int          cyc;
        logic        wr;
        logic        exc;
        logic        chk;
        logic [15:0] data;
        logic [2:0]  idx;
    } ret_t;

    op_t  dq[$];
    ret_t rq[$];
    int   acc_log[$];

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;
    int busy_end = -1, req_lo = 1, req_hi = 0, g_cyc = -1, rv_cyc = -1, fl_cyc = -1;
    logic [15:0] p_addr = '0, p_wdata = '0, p_rdat = '0;
    logic        p_we = 0, p_wr = 0, p_sup = 0, p_use_rd = 0;
    logic [2:0]  p_idx = '0;
    logic        just_reset = 0;

    logic        obs_wb[MAXC];
    logic        obs_exc[MAXC];
    logic        obs_wr[MAXC];
    logic        obs_req[MAXC];
    logic        obs_we[MAXC];
    logic        obs_stall[MAXC];
    logic [15:0] obs_data[MAXC];
    logic [15:0] obs_wdata[MAXC];
    logic [2:0]  obs_rd[MAXC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, exp);
        end
    endtask

    function automatic op_t mk(input int kind, input logic [15:0] a, input logic [15:0] w,
                               input logic [2:0] idx, input logic wr, input int d, input int r,
                               input int foff, input logic use_rd, input logic [15:0] rdat);
        op_t o;
        o.kind = kind; o.a = a; o.w = w; o.idx = idx; o.wr = wr;
        o.d = d; o.r = r; o.foff = foff; o.use_rd = use_rd; o.rdat = rdat;
        return o;
    endfunction

    function automatic op_t rand_op();
        op_t o;
        o.kind   = int'($urandom_range(0, 2));
        o.a      = 16'($urandom);
        o.w      = 16'($urandom);
        o.idx    = 3'($urandom);
        o.wr     = 1'($urandom);
        o.d      = int'($urandom_range(0, 3));
        o.r      = int'($urandom_range(0, 5));
        o.foff   = ($urandom_range(0, 4) == 0) ? 99 : -1;
        o.use_rd = 1'b0;
        o.rdat   = 16'h0000;
        return o;
    endfunction

    // Build the timeline of an instruction accepted in the current cycle.
    task automatic plan(input op_t o);
        int g, r, e, f;
        acc_log.push_back(cyc);
        if (o.kind == 0) begin
            rq.push_back('{cyc + 1, o.wr, 1'b0, 1'b1, o.a, o.idx});
            return;
        end
        g = cyc + 1 + o.d;
        p_addr = o.a; p_wdata = o.w; p_we = (o.kind == 2); p_wr = o.wr; p_idx = o.idx;
        p_use_rd = o.use_rd; p_rdat = o.rdat;
        if (o.kind == 2) begin
            e = g;
            r = -1;
        end else begin
            r = g + 1 + o.r;
            if (r <= g + T - 1) begin
                e = r;
            end else begin
                e = g + T - 1;
                r = -1;
            end
        end
        if (o.foff == 99) f = int'($urandom_range(cyc + 1, e));
        else if (o.foff >= 0) f = cyc + 1 + o.foff;
        else f = -1;
        if (o.kind == 1 && f == e && f > g) f = f - 1;
        req_lo = cyc + 1;
        fl_cyc = f;
        if (f >= 0 && f < g) begin
            req_hi = f; busy_end = f; g_cyc = -1; rv_cyc = -1;
        end else begin
            req_hi = g; busy_end = e; g_cyc = g; rv_cyc = r;
            p_sup = (f >= 0);
            if (!p_sup && o.kind == 2) rq.push_back('{g + 1, 1'b0, 1'b0, 1'b0, 16'h0, 3'h0});
            if (!p_sup && o.kind == 1 && r < 0) rq.push_back('{e + 1, 1'b0, 1'b1, 1'b0, 16'h0, 3'h0});
        end
    endtask

    task automatic run_cycle(input logic allow_rand, input logic do_rst);
        logic busy, have, exp_req;
        op_t  o;
        busy = (cyc <= busy_end);
        have = 1'b0;
        rst                = ~do_rst;
        alu_output_valid   = 1'b0;
        ldst_valid_idix_p1 = 1'b0;
        st_idix_p1         = 1'b0;
        rd_p1              = 16'($urandom);
        rt_p1              = 16'($urandom);
        rd_idx_p1          = 3'($urandom);
        wr_idix_p1         = 1'($urandom);
        flush_p1           = 1'b0;
        dmem_gnt           = 1'b0;
        dmem_rvalid        = 1'b0;
        dmem_rdata         = 16'($urandom);
        if (do_rst) begin
            dmem_rvalid = 1'b1;
            flush_p1    = 1'($urandom);
        end else if (!busy) begin
            if (dq.size() > 0) begin
                o = dq.pop_front();
                have = 1'b1;
            end else if (allow_rand && $urandom_range(0, 3) != 0) begin
                o = rand_op();
                have = 1'b1;
            end
            if (allow_rand) begin
                dmem_gnt    = 1'($urandom);
                dmem_rvalid = 1'($urandom);
                flush_p1    = ($urandom_range(0, 9) == 0);
            end
            if (have) begin
                alu_output_valid   = 1'b1;
                ldst_valid_idix_p1 = (o.kind != 0);
                st_idix_p1         = (o.kind == 2);
                rd_p1              = o.a;
                rt_p1              = o.w;
                rd_idx_p1          = o.idx;
                wr_idix_p1         = o.wr;
                if (!flush_p1) plan(o);
            end
        end else begin
            alu_output_valid   = 1'($urandom);
            ldst_valid_idix_p1 = 1'($urandom);
            st_idix_p1         = 1'($urandom);
            flush_p1           = (cyc == fl_cyc);
            dmem_gnt           = (cyc == g_cyc) || (cyc > req_hi && 1'($urandom));
            if (cyc == rv_cyc) begin
                dmem_rvalid = 1'b1;
                if (p_use_rd) dmem_rdata = p_rdat;
                if (!p_sup) rq.push_back('{cyc + 1, p_wr, 1'b0, 1'b1, dmem_rdata, p_idx});
            end
        end

        @(negedge clk);
        exp_req = (cyc >= req_lo) && (cyc <= req_hi);
        chk("stall", mem_stall_p1, (cyc <= busy_end));
        chk("req", dmem_req, exp_req);
        if (exp_req) begin
            chk("we", dmem_we, p_we);
            chk("addr", dmem_addr, p_addr);
            if (p_we) chk("wdata", dmem_wdata, p_wdata);
        end else begin
            chk("we_idle", dmem_we, 1'b0);
        end
        if (rq.size() > 0 && rq[0].cyc == cyc) begin
            chk("wb_valid", wb_valid, 1'b1);
            chk("wb_excep", wb_excep, rq[0].exc);
            chk("wb_wr", wb_wr, rq[0].wr);
            if (rq[0].chk) begin
                chk("wb_data", wb_data, rq[0].data);
                chk("wb_rd", wb_rd, rq[0].idx);
            end
            rq.delete(0);
        end else begin
            chk("wb_valid_idle", wb_valid, 1'b0);
            chk("wb_excep_idle", wb_excep, 1'b0);
        end
        if (just_reset) begin
            chk("rst_wb_data", wb_data, 16'h0);
            chk("rst_wb_rd", wb_rd, 3'h0);
            chk("rst_wb_wr", wb_wr, 1'b0);
            chk("rst_addr", dmem_addr, 16'h0);
            chk("rst_wdata", dmem_wdata, 16'h0);
            just_reset = 1'b0;
        end
        if (cyc < MAXC) begin
            obs_wb[cyc] = wb_valid;   obs_exc[cyc] = wb_excep; obs_wr[cyc] = wb_wr;
            obs_req[cyc] = dmem_req;  obs_we[cyc] = dmem_we;   obs_stall[cyc] = mem_stall_p1;
            obs_data[cyc] = wb_data;  obs_wdata[cyc] = dmem_wdata; obs_rd[cyc] = wb_rd;
        end
        @(posedge clk);
        #1;
        if (do_rst) begin
            busy_end = cyc; req_lo = 1; req_hi = 0; g_cyc = -1; rv_cyc = -1; fl_cyc = -1;
            while (rq.size() > 0 && rq[rq.size() - 1].cyc > cyc) rq.delete(rq.size() - 1);
            just_reset = 1'b1;
        end
        cyc++;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((dq.size() > 0 || cyc <= busy_end || rq.size() > 0) && n < 200) begin
            run_cycle(1'b0, 1'b0);
            n++;
        end
        chk("drain_bound", (n < 200), 1'b1);
        run_cycle(1'b0, 1'b0);
        run_cycle(1'b0, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int i = 0; i < MAXC; i++) begin
            obs_wb[i] = 0; obs_exc[i] = 0; obs_wr[i] = 0; obs_req[i] = 0; obs_we[i] = 0;
            obs_stall[i] = 0; obs_data[i] = 0; obs_wdata[i] = 0; obs_rd[i] = 0;
        end
        rst = 1'b0; alu_output_valid = 0; ldst_valid_idix_p1 = 0; st_idix_p1 = 0;
        rd_p1 = 0; rt_p1 = 0; rd_idx_p1 = 0; wr_idix_p1 = 0; flush_p1 = 0;
        dmem_gnt = 0; dmem_rvalid = 1'b1; dmem_rdata = 16'hFFFF;
        @(posedge clk);
        #1;
        cyc = 1;
        just_reset = 1'b1;
        run_cycle(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) run_cycle(1'b0, 1'b0);

        // Three back-to-back ALU ops.
        acc_log.delete();
        dq.push_back(mk(0, 16'h0001, 16'h0, 3'd1, 1'b1, 0, 0, -1, 1'b0, 16'h0));
        dq.push_back(mk(0, 16'h0002, 16'h0, 3'd2, 1'b1, 0, 0, -1, 1'b0, 16'h0));
        dq.push_back(mk(0, 16'h0003, 16'h0, 3'd3, 1'b1, 0, 0, -1, 1'b0, 16'h0));
        drain();
        n = acc_log[0];
        chk("alu3_wb", {obs_wb[n + 1], obs_wb[n + 2], obs_wb[n + 3]}, 3'b111);
        chk("alu3_data", obs_data[n + 3], 16'h0003);
        chk("alu3_rd", obs_rd[n + 2], 3'd2);
        chk("alu3_stall", {obs_stall[n], obs_stall[n + 1], obs_stall[n + 2]}, 3'b000);

        // Load 0x0040, grant after 3 wait cycles, data two cycles after grant.
        acc_log.delete();
        dq.push_back(mk(1, 16'h0040, 16'h0, 3'd5, 1'b1, 3, 1, -1, 1'b1, 16'hBEEF));
        drain();
        n = acc_log[0];
        chk("ld_req", {obs_req[n + 1], obs_req[n + 2], obs_req[n + 3], obs_req[n + 4], obs_req[n + 5]}, 5'b11110);
        chk("ld_stall", {obs_stall[n], obs_stall[n + 1], obs_stall[n + 2], obs_stall[n + 3],
                         obs_stall[n + 4], obs_stall[n + 5], obs_stall[n + 6], obs_stall[n + 7]}, 8'b1111_1110);
        chk("ld_wb", {obs_wb[n + 6], obs_wb[n + 7]}, 2'b01);
        chk("ld_data", obs_data[n + 7], 16'hBEEF);
        chk("ld_rd", obs_rd[n + 7], 3'd5);
        chk("ld_wr", obs_wr[n + 7], 1'b1);

        // Store with immediate grant.
        acc_log.delete();
        dq.push_back(mk(2, 16'h0010, 16'h1234, 3'd4, 1'b1, 0, 0, -1, 1'b0, 16'h0));
        drain();
        n = acc_log[0];
        chk("st_we", obs_we[n + 1], 1'b1);
        chk("st_wdata", obs_wdata[n + 1], 16'h1234);
        chk("st_wb", {obs_wb[n + 1], obs_wb[n + 2]}, 2'b01);
        chk("st_wr", obs_wr[n + 2], 1'b0);

        // Load that never gets a response, then an ALU op.
        acc_log.delete();
        dq.push_back(mk(1, 16'h0080, 16'h0, 3'd2, 1'b1, 0, 10, -1, 1'b0, 16'h0));
        dq.push_back(mk(0, 16'h5A5A, 16'h0, 3'd6, 1'b1, 0, 0, -1, 1'b0, 16'h0));
        drain();
        n = acc_log[0];
        chk("to_exc", {obs_wb[n + 4], obs_exc[n + 4], obs_wb[n + 5], obs_exc[n + 5]}, 4'b0011);
        chk("to_wr", obs_wr[n + 5], 1'b0);
        chk("to_next", {obs_wb[n + 6], obs_exc[n + 6]}, 2'b10);
        chk("to_next_data", obs_data[n + 6], 16'h5A5A);

        // Load flushed in WAIT, response arrives later; then an ALU op.
        acc_log.delete();
        dq.push_back(mk(1, 16'h0100, 16'h0, 3'd3, 1'b1, 0, 2, 1, 1'b0, 16'h0));
        dq.push_back(mk(0, 16'h0777, 16'h0, 3'd7, 1'b1, 0, 0, -1, 1'b0, 16'h0));
        drain();
        n = acc_log[0];
        chk("fl_nowb", {obs_wb[n + 1], obs_wb[n + 2], obs_wb[n + 3], obs_wb[n + 4], obs_wb[n + 5]}, 5'b00000);
        chk("fl_stall", {obs_stall[n + 4], obs_stall[n + 5]}, 2'b10);
        chk("fl_next", obs_wb[n + 6], 1'b1);
        chk("fl_next_data", obs_data[n + 6], 16'h0777);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 2000; i++) begin
            run_cycle(1'b1, ($urandom_range(0, 199) == 0));
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
